// File: rtl/monkey_move_controller.sv
// Purpose : per-frame sprite motion controller (walk, jump, gravity, edge-collision blocking).
// Latency : position/state update on a startOfFrame cycle, visible the following cycle.
// Backpressure: none; collisions between frames are latched into sticky edge flags.
//
// Ports:
//   clk, resetN              - clock, asynchronous active-low reset
//   startOfFrame             - one-cycle pulse per VGA frame; all motion happens here
//   leftKey/rightKey/jumpKey - level-sensitive debounced keys, sampled on startOfFrame
//   collision, HitEdgeCode   - sprite/obstacle overlap and {Left,Top,Right,Bottom} edge code
//   topLeftX, topLeftY       - registered sprite top-left position
//   onGround                 - registered, high while the FSM is in GROUND
module monkey_move_controller #(
    parameter logic [10:0] INITIAL_X   = 11'd280,
    parameter logic [10:0] INITIAL_Y   = 11'd185,
    parameter int          X_SPEED     = 2,
    parameter int          JUMP_SPEED  = -6,
    parameter int          GRAVITY     = 1,
    parameter int          MAX_Y_SPEED = 6,
    parameter int          X_MAX       = 607,
    parameter int          Y_MAX       = 447
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        jumpKey,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        onGround
);

    typedef enum logic {
        ST_GROUND = 1'b0,
        ST_AIR    = 1'b1
    } state_t;

    localparam logic signed [11:0] LP_X_SPEED = 12'(X_SPEED);
    localparam logic signed [11:0] LP_X_MAX   = 12'(X_MAX);
    localparam logic signed [11:0] LP_Y_MAX   = 12'(Y_MAX);
    localparam logic signed [7:0]  LP_JUMP    = 8'(JUMP_SPEED);
    localparam logic signed [8:0]  LP_GRAVITY = 9'(GRAVITY);
    localparam logic signed [8:0]  LP_MAX_SPD = 9'(MAX_Y_SPEED);

    state_t             r_state;
    logic signed [7:0]  r_y_speed;
    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic               r_on_ground;
    logic               r_hit_l;
    logic               r_hit_t;
    logic               r_hit_r;
    logic               r_hit_b;

    // Edge hits of the current cycle.
    logic w_col_l;
    logic w_col_t;
    logic w_col_r;
    logic w_col_b;

    assign w_col_l = collision & HitEdgeCode[3];
    assign w_col_t = collision & HitEdgeCode[2];
    assign w_col_r = collision & HitEdgeCode[1];
    assign w_col_b = collision & HitEdgeCode[0];

    // Horizontal candidates, computed in signed 12 bits so the left move
    // can go negative and clamp instead of wrapping.
    logic signed [11:0] w_x_s;
    logic signed [11:0] w_x_plus;
    logic signed [11:0] w_x_minus;
    logic [10:0]        w_x_right;
    logic [10:0]        w_x_left;
    logic               w_move_r;
    logic               w_move_l;

    assign w_x_s     = $signed({1'b0, r_x});
    assign w_x_plus  = w_x_s + LP_X_SPEED;
    assign w_x_minus = w_x_s - LP_X_SPEED;
    assign w_x_right = (w_x_plus > LP_X_MAX) ? LP_X_MAX[10:0] : w_x_plus[10:0];
    assign w_x_left  = (w_x_minus < 12'sd0) ? 11'd0 : w_x_minus[10:0];

    // Flags are the ones accumulated before this cycle; a collision that
    // lands on the startOfFrame cycle itself belongs to the next frame.
    assign w_move_r = rightKey & ~leftKey & ~r_hit_r;
    assign w_move_l = leftKey & ~rightKey & ~r_hit_l;

    // Vertical candidate and the gravity-updated speed (9 bits so the
    // increment cannot overflow before saturation).
    logic signed [11:0] w_y_sum;
    logic signed [8:0]  w_spd_inc;
    logic signed [7:0]  w_spd_next;

    assign w_y_sum    = $signed({1'b0, r_y}) + {{4{r_y_speed[7]}}, r_y_speed};
    assign w_spd_inc  = {r_y_speed[7], r_y_speed} + LP_GRAVITY;
    assign w_spd_next = (w_spd_inc > LP_MAX_SPD) ? LP_MAX_SPD[7:0] : w_spd_inc[7:0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_AIR;
            r_y_speed   <= 8'sd0;
            r_x         <= INITIAL_X;
            r_y         <= INITIAL_Y;
            r_on_ground <= 1'b0;
            r_hit_l     <= 1'b0;
            r_hit_t     <= 1'b0;
            r_hit_r     <= 1'b0;
            r_hit_b     <= 1'b0;
        end else if (startOfFrame) begin
            // Consume the flags for this update, then restart them with
            // whatever collides in this very cycle.
            r_hit_l <= w_col_l;
            r_hit_t <= w_col_t;
            r_hit_r <= w_col_r;
            r_hit_b <= w_col_b;

            if (w_move_r) begin
                r_x <= w_x_right;
            end else if (w_move_l) begin
                r_x <= w_x_left;
            end

            case (r_state)
                ST_GROUND: begin
                    if (jumpKey) begin
                        r_state     <= ST_AIR;
                        r_y_speed   <= LP_JUMP;
                        r_on_ground <= 1'b0;
                    end else if (!r_hit_b) begin
                        // Nothing underneath any more: walk off the ledge.
                        r_state     <= ST_AIR;
                        r_y_speed   <= 8'sd0;
                        r_on_ground <= 1'b0;
                    end
                end
                ST_AIR: begin
                    if (r_hit_b && (r_y_speed > 8'sd0)) begin
                        r_state     <= ST_GROUND;
                        r_y_speed   <= 8'sd0;
                        r_on_ground <= 1'b1;
                    end else if (r_hit_t && (r_y_speed < 8'sd0)) begin
                        // Head bump: stop rising, fall from here next frame.
                        r_y_speed <= 8'sd0;
                    end else if (w_y_sum >= LP_Y_MAX) begin
                        r_y         <= LP_Y_MAX[10:0];
                        r_state     <= ST_GROUND;
                        r_y_speed   <= 8'sd0;
                        r_on_ground <= 1'b1;
                    end else if (w_y_sum < 12'sd0) begin
                        r_y       <= 11'd0;
                        r_y_speed <= w_spd_next;
                    end else begin
                        r_y       <= w_y_sum[10:0];
                        r_y_speed <= w_spd_next;
                    end
                end
                default: begin
                    r_state     <= ST_AIR;
                    r_y_speed   <= 8'sd0;
                    r_on_ground <= 1'b0;
                end
            endcase
        end else begin
            r_hit_l <= r_hit_l | w_col_l;
            r_hit_t <= r_hit_t | w_col_t;
            r_hit_r <= r_hit_r | w_col_r;
            r_hit_b <= r_hit_b | w_col_b;
        end
    end

    assign topLeftX = r_x;
    assign topLeftY = r_y;
    assign onGround = r_on_ground;

endmodule

// File: tb/tb_monkey_move_controller.sv
// Purpose : directed self-checking bench for monkey_move_controller.
// Latency : each frame is 4 cycles; outputs sampled on the negedge after startOfFrame.
// Backpressure: not applicable.
module tb_monkey_move_controller;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        leftKey;
    logic        rightKey;
    logic        jumpKey;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        onGround;

    int total = 0;
    int bad   = 0;

    monkey_move_controller dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .leftKey      (leftKey),
        .rightKey     (rightKey),
        .jumpKey      (jumpKey),
        .collision    (collision),
        .HitEdgeCode  (HitEdgeCode),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .onGround     (onGround)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: optional mid-frame collision, then a startOfFrame cycle
    // carrying its own optional collision. Returns on the negedge after the update.
    task automatic frame(input logic mid_col, input logic [3:0] mid_code,
                         input logic sof_col, input logic [3:0] sof_code);
        @(negedge clk);
        collision   = mid_col;
        HitEdgeCode = mid_code;
        @(negedge clk);
        collision   = 1'b0;
        HitEdgeCode = 4'b0000;
        @(negedge clk);
        startOfFrame = 1'b1;
        collision    = sof_col;
        HitEdgeCode  = sof_code;
        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'b0000;
    endtask

    task automatic frame_free();
        frame(1'b0, 4'b0000, 1'b0, 4'b0000);
    endtask

    task automatic frame_b();
        frame(1'b1, 4'b0001, 1'b0, 4'b0000);
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        leftKey      = 1'b0;
        rightKey     = 1'b0;
        jumpKey      = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'b0000;

        #12;
        chk("reset_x", 32'(topLeftX), 32'd280);
        chk("reset_y", 32'(topLeftY), 32'd185);
        chk("reset_ground", 32'(onGround), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("no_update_without_sof", 32'(topLeftY), 32'd185);

        // Free fall from reset: speed 0,1,2,... saturating at 6.
        frame_free(); chk("fall_f1", 32'(topLeftY), 32'd185);
        frame_free(); chk("fall_f2", 32'(topLeftY), 32'd186);
        frame_free(); chk("fall_f3", 32'(topLeftY), 32'd188);
        for (int i = 0; i < 18; i++) frame_free();
        chk("fall_f21", 32'(topLeftY), 32'd290);

        // Land on hitB (Y not advanced), then jump with hitB held every frame.
        frame_b();
        chk("land_y", 32'(topLeftY), 32'd290);
        chk("land_ground", 32'(onGround), 32'd1);
        jumpKey = 1'b1;
        frame_b();
        chk("jump_start_y", 32'(topLeftY), 32'd290);
        chk("jump_start_air", 32'(onGround), 32'd0);
        frame_b();   // jumpKey still held in AIR: ignored
        chk("jump_y1", 32'(topLeftY), 32'd284);
        jumpKey = 1'b0;
        frame_b(); chk("jump_y2", 32'(topLeftY), 32'd279);
        frame_b(); chk("jump_y3", 32'(topLeftY), 32'd275);
        frame_b(); frame_b(); frame_b();
        chk("apex_y", 32'(topLeftY), 32'd269);
        frame_b();   // speed 0: hitB not honoured yet
        chk("apex_y_zero_spd", 32'(topLeftY), 32'd269);
        chk("apex_air", 32'(onGround), 32'd0);
        frame_b();   // speed 1 > 0 with hitB: land
        chk("relanded", 32'(onGround), 32'd1);
        chk("relanded_y", 32'(topLeftY), 32'd269);

        // Left movement down to the 0 clamp.
        leftKey = 1'b1;
        frame_b(); chk("left_1", 32'(topLeftX), 32'd278);
        for (int i = 0; i < 139; i++) frame_b();
        chk("left_at_0", 32'(topLeftX), 32'd0);
        frame_b(); chk("left_clamp_a", 32'(topLeftX), 32'd0);
        frame_b(); chk("left_clamp_b", 32'(topLeftX), 32'd0);
        leftKey = 1'b0;

        // Right edge flag blocks the move for one frame only.
        rightKey = 1'b1;
        frame(1'b1, 4'b0011, 1'b0, 4'b0000);
        chk("hitR_block", 32'(topLeftX), 32'd0);
        frame_b(); chk("hitR_cleared", 32'(topLeftX), 32'd2);

        // Collision on the startOfFrame cycle affects the following frame.
        frame(1'b1, 4'b0001, 1'b1, 4'b0011);
        chk("sof_col_ignored", 32'(topLeftX), 32'd4);
        frame_free();
        chk("sof_col_applied", 32'(topLeftX), 32'd4);
        chk("sof_col_hitB_kept", 32'(onGround), 32'd1);
        frame_b(); chk("sof_col_cleared", 32'(topLeftX), 32'd6);

        // Right movement up to the X_MAX clamp.
        for (int i = 0; i < 300; i++) frame_b();
        chk("right_606", 32'(topLeftX), 32'd606);
        frame_b(); chk("right_clamp_a", 32'(topLeftX), 32'd607);
        frame_b(); chk("right_clamp_b", 32'(topLeftX), 32'd607);
        leftKey = 1'b1;
        frame_b(); chk("both_keys", 32'(topLeftX), 32'd607);
        leftKey  = 1'b0;
        rightKey = 1'b0;

        // Walk off the ledge and fall to the bottom limit.
        frame_free();
        chk("walkoff_air", 32'(onGround), 32'd0);
        chk("walkoff_y", 32'(topLeftY), 32'd269);
        for (int i = 0; i < 6; i++) frame_free();
        chk("drop_a6", 32'(topLeftY), 32'd284);
        for (int i = 0; i < 27; i++) frame_free();
        chk("drop_a33", 32'(topLeftY), 32'd446);
        chk("drop_a33_air", 32'(onGround), 32'd0);
        frame_free();
        chk("ymax_clamp", 32'(topLeftY), 32'd447);
        chk("ymax_ground", 32'(onGround), 32'd1);

        // Jump, latch a left-edge flag, then reset mid-jump.
        jumpKey = 1'b1;
        frame_free();
        jumpKey = 1'b0;
        frame_free();
        chk("jump_from_floor", 32'(topLeftY), 32'd441);
        @(negedge clk);
        collision   = 1'b1;
        HitEdgeCode = 4'b1000;
        @(negedge clk);
        collision   = 1'b0;
        HitEdgeCode = 4'b0000;
        #2 resetN = 1'b0;
        #1;
        chk("midjump_reset_x", 32'(topLeftX), 32'd280);
        chk("midjump_reset_y", 32'(topLeftY), 32'd185);
        chk("midjump_reset_air", 32'(onGround), 32'd0);
        @(negedge clk);
        resetN  = 1'b1;
        leftKey = 1'b1;
        frame_free();
        chk("post_reset_flag_gone", 32'(topLeftX), 32'd278);
        chk("post_reset_y", 32'(topLeftY), 32'd185);
        leftKey = 1'b0;
        frame_free();
        chk("post_reset_fall", 32'(topLeftY), 32'd186);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
